// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types for the writeback / register-file slice.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/wb_select.sv
// Writeback value select: load data or ALU result, purely combinational.
module wb_select #(
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic              memtoreg,
    input  logic [DATA_W-1:0] readdata,
    input  logic [DATA_W-1:0] aluresult,
    output logic [DATA_W-1:0] data
);

    assign data = memtoreg ? readdata : aluresult;

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage register file: commit, two ID read ports, registered debug port, retire counter.
// Optional WB_BYPASS_EN: same-cycle write-through from the writeback value to the ID read ports.
module wb_regfile #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_regwrite,
    input  logic              wb_memtoreg,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_readdata,
    input  logic [DATA_W-1:0] wb_aluresult,
    output logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  retire_count
);

    import cpu_pkg::*;

    localparam int NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_ZERO = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              commit;

    wb_select #(.DATA_W(DATA_W)) u_wb_select (
        .memtoreg  (wb_memtoreg),
        .readdata  (wb_readdata),
        .aluresult (wb_aluresult),
        .data      (wb_data)
    );

    assign commit = wb_regwrite && (wb_rd != IDX_ZERO);

    // Index 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        rs_data = (rs_addr == IDX_ZERO) ? '0 : regs[rs_addr];
        rt_data = (rt_addr == IDX_ZERO) ? '0 : regs[rt_addr];
`ifdef WB_BYPASS_EN
        if (commit && (rs_addr == wb_rd)) begin
            rs_data = wb_data;
        end
        if (commit && (rt_addr == wb_rd)) begin
            rt_data = wb_data;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_data <= '0;
        end else begin
            dbg_data <= regs[dbg_addr];
        end
    end

    // Saturating: holds at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_count <= '0;
        end else if (commit && (retire_count != '1)) begin
            retire_count <= retire_count + CNT_W'(1);
        end
    end

endmodule
